axi_read_arbiter: RTL and testbench

- Shares the single AXI4 read master port between two requesters: instruction fetch (if_*) and data-memory stage (dm_*).
- Serves one burst at a time. Forwards AR fields to memory, then routes R beats back only to the granted requester.
- Tags ARID by requester and checks returned RID and burst length.
- Sits between the fetch/memory pipeline stages and the top-level m_axi_* read port.

---
 rtl/axi_arb_pkg.sv | 20 ++
 rtl/axi_arb_grant.sv | 37 +++
 rtl/axi_read_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_axi_read_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_arb_pkg.sv
// axi_arb_pkg: shared types and constants for the AXI read arbiter.
//   state_e     : arbiter FSM states
//   GRANT_*     : grant encoding, which is also the low ARID bit
//   BURST_*/SIZE_8B : AXI field encodings used by the requesters
package axi_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_e;

   localparam logic       GRANT_IF   = 1'b0;
   localparam logic       GRANT_DM   = 1'b1;

   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [1:0] BURST_WRAP = 2'b10;
   localparam logic [2:0] SIZE_8B    = 3'b011;

endpackage

// File: rtl/axi_arb_grant.sv
// axi_arb_grant: combinational winner picker for the two read requesters.
//   if_req, dm_req : pending AR requests
//   last_grant     : requester that won the previous grant
//   grant          : winner (GRANT_IF / GRANT_DM), meaningful when grant_valid
//   grant_valid    : at least one request pending
// Build option: ARB_ROUND_ROBIN_EN alternates the winner on contention;
// without it the data stage always beats fetch.
module axi_arb_grant
   import axi_arb_pkg::*;
(
   input  logic if_req,
   input  logic dm_req,
   input  logic last_grant,
   output logic grant,
   output logic grant_valid
);

   always_comb begin
      grant_valid = if_req | dm_req;
      grant       = GRANT_DM;
      if (if_req && !dm_req) begin
         grant = GRANT_IF;
      end
`ifdef ARB_ROUND_ROBIN_EN
      else if (if_req && dm_req) begin
         grant = ~last_grant;
      end
`endif
   end

`ifndef ARB_ROUND_ROBIN_EN
   // Fixed priority ignores history.
   logic unused_last_grant;
   assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: shares one AXI4 read master between instruction fetch
// (if_*) and the data-memory stage (dm_*), one burst at a time.
//   clk, reset        : clock, asynchronous active-high reset
//   if_ar*/dm_ar*     : requester AR channels (arready is combinational in IDLE)
//   if_r*/dm_r*       : requester R channels; rdata is broadcast during DATA
//   m_axi_ar*/m_axi_r*: master read port, ARID = {zeros, grant}
//   err_rid, err_len  : sticky protocol errors, cleared only by reset
// Build option: ARB_ROUND_ROBIN_EN selects round-robin arbitration
// (default: fixed priority, data stage wins).
//
// state | meaning
// IDLE  | waiting for a request; winner gets arready this cycle
// ADDR  | presenting latched AR fields until m_axi_arready
// DATA  | routing R beats to the granted requester until accepted rlast
module axi_read_arbiter
   import axi_arb_pkg::*;
#(
   parameter int ID_WIDTH   = 13,
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] if_araddr,
   input  logic [7:0]            if_arlen,
   input  logic [2:0]            if_arsize,
   input  logic [1:0]            if_arburst,
   input  logic                  if_arvalid,
   output logic                  if_arready,
   output logic [DATA_WIDTH-1:0] if_rdata,
   output logic                  if_rlast,
   output logic                  if_rvalid,
   input  logic                  if_rready,
   input  logic [ADDR_WIDTH-1:0] dm_araddr,
   input  logic [7:0]            dm_arlen,
   input  logic [2:0]            dm_arsize,
   input  logic [1:0]            dm_arburst,
   input  logic                  dm_arvalid,
   output logic                  dm_arready,
   output logic [DATA_WIDTH-1:0] dm_rdata,
   output logic                  dm_rlast,
   output logic                  dm_rvalid,
   input  logic                  dm_rready,
   output logic [ID_WIDTH-1:0]   m_axi_arid,
   output logic [ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [7:0]            m_axi_arlen,
   output logic [2:0]            m_axi_arsize,
   output logic [1:0]            m_axi_arburst,
   output logic                  m_axi_arvalid,
   input  logic                  m_axi_arready,
   input  logic [ID_WIDTH-1:0]   m_axi_rid,
   input  logic [DATA_WIDTH-1:0] m_axi_rdata,
   input  logic                  m_axi_rlast,
   input  logic                  m_axi_rvalid,
   output logic                  m_axi_rready,
   output logic                  err_rid,
   output logic                  err_len
);

   state_e                state_q, state_d;
   logic                  grant_q, grant_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [7:0]            len_q, len_d;
   logic [2:0]            size_q, size_d;
   logic [1:0]            burst_q, burst_d;
   logic [7:0]            beat_cnt_q, beat_cnt_d;
   logic                  err_rid_q, err_rid_d;
   logic                  err_len_q, err_len_d;
   logic                  last_grant;
   logic                  pick, pick_valid;
   logic                  rid_ok;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_grant_q, last_grant_d;
   assign last_grant = last_grant_q;
`else
   assign last_grant = GRANT_IF;
`endif

   axi_arb_grant u_grant (
      .if_req      (if_arvalid),
      .dm_req      (dm_arvalid),
      .last_grant  (last_grant),
      .grant       (pick),
      .grant_valid (pick_valid)
   );

   assign m_axi_arid    = {{(ID_WIDTH-1){1'b0}}, grant_q};
   assign m_axi_araddr  = addr_q;
   assign m_axi_arlen   = len_q;
   assign m_axi_arsize  = size_q;
   assign m_axi_arburst = burst_q;
   assign err_rid       = err_rid_q;
   assign err_len       = err_len_q;
   assign rid_ok        = (m_axi_rid == m_axi_arid);

   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      addr_d        = addr_q;
      len_d         = len_q;
      size_d        = size_q;
      burst_d       = burst_q;
      beat_cnt_d    = beat_cnt_q;
      err_rid_d     = err_rid_q;
      err_len_d     = err_len_q;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_d  = last_grant_q;
`endif
      if_arready    = 1'b0;
      dm_arready    = 1'b0;
      m_axi_arvalid = 1'b0;
      m_axi_rready  = 1'b0;
      if_rvalid     = 1'b0;
      dm_rvalid     = 1'b0;
      if_rlast      = 1'b0;
      dm_rlast      = 1'b0;
      if_rdata      = '0;
      dm_rdata      = '0;

      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               if_arready = (pick == GRANT_IF);
               dm_arready = (pick == GRANT_DM);
               grant_d    = pick;
               addr_d     = (pick == GRANT_DM) ? dm_araddr  : if_araddr;
               len_d      = (pick == GRANT_DM) ? dm_arlen   : if_arlen;
               size_d     = (pick == GRANT_DM) ? dm_arsize  : if_arsize;
               burst_d    = (pick == GRANT_DM) ? dm_arburst : if_arburst;
`ifdef ARB_ROUND_ROBIN_EN
               last_grant_d = pick;
`endif
               state_d    = ADDR;
            end
         end
         ADDR: begin
            m_axi_arvalid = 1'b1;
            if (m_axi_arready) begin
               beat_cnt_d = '0;
               state_d    = DATA;
            end
         end
         DATA: begin
            if_rdata = m_axi_rdata;
            dm_rdata = m_axi_rdata;
            if (!rid_ok) begin
               // Foreign beat: swallow it so the master side cannot stall.
               m_axi_rready = 1'b1;
            end else begin
               m_axi_rready = (grant_q == GRANT_DM) ? dm_rready : if_rready;
               if_rvalid    = m_axi_rvalid && (grant_q == GRANT_IF);
               dm_rvalid    = m_axi_rvalid && (grant_q == GRANT_DM);
               if_rlast     = m_axi_rlast  && (grant_q == GRANT_IF);
               dm_rlast     = m_axi_rlast  && (grant_q == GRANT_DM);
            end
            if (m_axi_rvalid && m_axi_rready) begin
               if (!rid_ok) begin
                  err_rid_d = 1'b1;
               end else begin
                  beat_cnt_d = beat_cnt_q + 8'd1;
                  if (m_axi_rlast != (beat_cnt_q == len_q)) begin
                     err_len_d = 1'b1;
                  end
                  if (m_axi_rlast) begin
                     state_d = IDLE;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         grant_q      <= GRANT_IF;
         addr_q       <= '0;
         len_q        <= '0;
         size_q       <= '0;
         burst_q      <= '0;
         beat_cnt_q   <= '0;
         err_rid_q    <= 1'b0;
         err_len_q    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         last_grant_q <= GRANT_IF;
`endif
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         addr_q       <= addr_d;
         len_q        <= len_d;
         size_q       <= size_d;
         burst_q      <= burst_d;
         beat_cnt_q   <= beat_cnt_d;
         err_rid_q    <= err_rid_d;
         err_len_q    <= err_len_d;
`ifdef ARB_ROUND_ROBIN_EN
         last_grant_q <= last_grant_d;
`endif
      end
   end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb_axi_read_arbiter: directed stimulus for axi_read_arbiter with a
// scoreboard. Stimulus pushes expected master AR transfers and expected
// requester R beats; a negedge monitor pops and compares on each handshake.
// The round-robin sequence runs only when ARB_ROUND_ROBIN_EN is defined.
module tb_axi_read_arbiter;
   import axi_arb_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [63:0] if_araddr, dm_araddr;
   logic [7:0]  if_arlen, dm_arlen;
   logic [2:0]  if_arsize, dm_arsize;
   logic [1:0]  if_arburst, dm_arburst;
   logic        if_arvalid, dm_arvalid, if_arready, dm_arready;
   logic [63:0] if_rdata, dm_rdata;
   logic        if_rlast, if_rvalid, if_rready, dm_rlast, dm_rvalid, dm_rready;
   logic [12:0] m_axi_arid, m_axi_rid;
   logic [63:0] m_axi_araddr, m_axi_rdata;
   logic [7:0]  m_axi_arlen;
   logic [2:0]  m_axi_arsize;
   logic [1:0]  m_axi_arburst;
   logic        m_axi_arvalid, m_axi_arready, m_axi_rlast, m_axi_rvalid, m_axi_rready;
   logic        err_rid, err_len;

   typedef struct {
      logic [12:0] id;
      logic [63:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
   } ar_t;
   typedef struct {
      logic        who;
      logic [63:0] data;
      logic        last;
   } r_t;

   ar_t exp_ar[$];
   r_t  exp_r[$];
   ar_t mon_ar;
   r_t  mon_r;
   int  n_checks = 0;
   int  n_fail = 0;
   int  beats_seen = 0;
   int  beats_before;

   always #5 clk = ~clk;

   axi_read_arbiter #(.ID_WIDTH(13), .ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
      .clk(clk), .reset(reset),
      .if_araddr(if_araddr), .if_arlen(if_arlen), .if_arsize(if_arsize),
      .if_arburst(if_arburst), .if_arvalid(if_arvalid), .if_arready(if_arready),
      .if_rdata(if_rdata), .if_rlast(if_rlast), .if_rvalid(if_rvalid), .if_rready(if_rready),
      .dm_araddr(dm_araddr), .dm_arlen(dm_arlen), .dm_arsize(dm_arsize),
      .dm_arburst(dm_arburst), .dm_arvalid(dm_arvalid), .dm_arready(dm_arready),
      .dm_rdata(dm_rdata), .dm_rlast(dm_rlast), .dm_rvalid(dm_rvalid), .dm_rready(dm_rready),
      .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
      .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rlast(m_axi_rlast),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
      .err_rid(err_rid), .err_len(err_len)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic pop_r(input logic who, input logic [63:0] data, input logic last);
      beats_seen++;
      if (exp_r.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL r_unexpected: requester %0d got beat 0x%0h, expected none", who, data);
      end else begin
         mon_r = exp_r.pop_front();
         chk("r_who", {63'd0, who}, {63'd0, mon_r.who});
         chk("r_data", data, mon_r.data);
         chk("r_last", {63'd0, last}, {63'd0, mon_r.last});
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (m_axi_arvalid && m_axi_arready) begin
            if (exp_ar.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL ar_unexpected: addr 0x%0h, expected none", m_axi_araddr);
            end else begin
               mon_ar = exp_ar.pop_front();
               chk("ar_id", {51'd0, m_axi_arid}, {51'd0, mon_ar.id});
               chk("ar_addr", m_axi_araddr, mon_ar.addr);
               chk("ar_len", {56'd0, m_axi_arlen}, {56'd0, mon_ar.len});
               chk("ar_size", {61'd0, m_axi_arsize}, {61'd0, mon_ar.size});
               chk("ar_burst", {62'd0, m_axi_arburst}, {62'd0, mon_ar.burst});
            end
         end
         if (if_rvalid && dm_rvalid) chk("rvalid_both", 64'd1, 64'd0);
         if (if_rvalid && if_rready) pop_r(1'b0, if_rdata, if_rlast);
         if (dm_rvalid && dm_rready) pop_r(1'b1, dm_rdata, dm_rlast);
      end
   end

   task automatic chk_all_zero(input string tag);
      chk({tag, "_if_arready"}, {63'd0, if_arready}, 64'd0);
      chk({tag, "_dm_arready"}, {63'd0, dm_arready}, 64'd0);
      chk({tag, "_if_rvalid"}, {63'd0, if_rvalid}, 64'd0);
      chk({tag, "_dm_rvalid"}, {63'd0, dm_rvalid}, 64'd0);
      chk({tag, "_if_rdata"}, if_rdata, 64'd0);
      chk({tag, "_m_arvalid"}, {63'd0, m_axi_arvalid}, 64'd0);
      chk({tag, "_m_rready"}, {63'd0, m_axi_rready}, 64'd0);
      chk({tag, "_m_arid"}, {51'd0, m_axi_arid}, 64'd0);
      chk({tag, "_m_araddr"}, m_axi_araddr, 64'd0);
      chk({tag, "_m_arlen"}, {56'd0, m_axi_arlen}, 64'd0);
      chk({tag, "_err_rid"}, {63'd0, err_rid}, 64'd0);
      chk({tag, "_err_len"}, {63'd0, err_len}, 64'd0);
   endtask

   // Called at posedge+1 of an IDLE cycle with only this requester asking.
   task automatic req_one(input logic who, input logic [63:0] a, input logic [7:0] l,
                          input logic [2:0] s, input logic [1:0] b);
      if (who) begin
         dm_arvalid = 1'b1; dm_araddr = a; dm_arlen = l; dm_arsize = s; dm_arburst = b;
      end else begin
         if_arvalid = 1'b1; if_araddr = a; if_arlen = l; if_arsize = s; if_arburst = b;
      end
      exp_ar.push_back('{id: {12'd0, who}, addr: a, len: l, size: s, burst: b});
      @(negedge clk);
      chk("arready_same_cycle", {63'd0, who ? dm_arready : if_arready}, 64'd1);
      chk("other_arready_low", {63'd0, who ? if_arready : dm_arready}, 64'd0);
      chk("m_arvalid_not_yet", {63'd0, m_axi_arvalid}, 64'd0);
      @(posedge clk); #1;
      if_arvalid = 1'b0;
      dm_arvalid = 1'b0;
   endtask

   task automatic addr_phase(input int stall);
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         chk("arvalid_hold", {63'd0, m_axi_arvalid}, 64'd1);
         @(posedge clk); #1;
      end
      m_axi_arready = 1'b1;
      @(negedge clk);
      chk("arvalid_next_cycle", {63'd0, m_axi_arvalid}, 64'd1);
      @(posedge clk); #1;
      m_axi_arready = 1'b0;
   endtask

   task automatic beat(input logic who, input logic [12:0] rid, input logic [63:0] d,
                       input logic last, input bit tog);
      bit   acc;
      int   cyc;
      logic fwd;
      fwd = (rid == {12'd0, who});
      m_axi_rvalid = 1'b1; m_axi_rid = rid; m_axi_rdata = d; m_axi_rlast = last;
      if (fwd) exp_r.push_back('{who: who, data: d, last: last});
      acc = 1'b0;
      cyc = 0;
      while (!acc && cyc < 20) begin
         if (tog) begin
            if (who) dm_rready = !dm_rready;
            else     if_rready = !if_rready;
         end
         @(negedge clk);
         if (!fwd) begin
            chk("bad_rid_rready_forced", {63'd0, m_axi_rready}, 64'd1);
            chk("bad_rid_not_fwd", {63'd0, who ? dm_rvalid : if_rvalid}, 64'd0);
         end else if (tog) begin
            chk("rready_mirror", {63'd0, m_axi_rready}, {63'd0, who ? dm_rready : if_rready});
         end
         acc = m_axi_rready;
         @(posedge clk); #1;
         cyc++;
      end
      if (!acc) begin
         n_checks++;
         n_fail++;
         $display("FAIL beat_timeout: beat 0x%0h not accepted, got rready 0 required 1", d);
      end
      m_axi_rvalid = 1'b0;
      m_axi_rlast  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      if_araddr = '0; if_arlen = '0; if_arsize = '0; if_arburst = '0; if_arvalid = 1'b0;
      dm_araddr = '0; dm_arlen = '0; dm_arsize = '0; dm_arburst = '0; dm_arvalid = 1'b0;
      if_rready = 1'b1; dm_rready = 1'b1;
      m_axi_arready = 1'b0; m_axi_rid = '0; m_axi_rdata = '0;
      m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("in_reset");
      reset = 1'b0;
      @(negedge clk);
      chk_all_zero("idle");
      @(posedge clk); #1;

      // 1: fetch-only wrap burst, two stall cycles on AR
      req_one(GRANT_IF, 64'h1000, 8'd7, SIZE_8B, BURST_WRAP);
      addr_phase(2);
      for (int b = 0; b < 8; b++) beat(GRANT_IF, 13'd0, 64'hA000 + 64'(b), b == 7, 1'b0);
      @(negedge clk);
      chk("t1_idle_rready", {63'd0, m_axi_rready}, 64'd0);
      chk("t1_err_rid", {63'd0, err_rid}, 64'd0);
      chk("t1_err_len", {63'd0, err_len}, 64'd0);
      chk("t1_r_drained", 64'(exp_r.size()), 64'd0);
      @(posedge clk); #1;

      // 2: simultaneous requests, dm wins, fetch follows one cycle after rlast
      if_arvalid = 1'b1; if_araddr = 64'h1000; if_arlen = 8'd7; if_arsize = SIZE_8B; if_arburst = BURST_INCR;
      dm_arvalid = 1'b1; dm_araddr = 64'h2000; dm_arlen = 8'd0; dm_arsize = SIZE_8B; dm_arburst = BURST_INCR;
      exp_ar.push_back('{id: 13'd1, addr: 64'h2000, len: 8'd0, size: SIZE_8B, burst: BURST_INCR});
      @(negedge clk);
      chk("t2_dm_arready", {63'd0, dm_arready}, 64'd1);
      chk("t2_if_arready", {63'd0, if_arready}, 64'd0);
      @(posedge clk); #1;
      dm_arvalid = 1'b0;
      addr_phase(0);
      beat(GRANT_DM, 13'd1, 64'hB0, 1'b1, 1'b0);
      exp_ar.push_back('{id: 13'd0, addr: 64'h1000, len: 8'd7, size: SIZE_8B, burst: BURST_INCR});
      @(negedge clk);
      chk("t2_if_granted_after_rlast", {63'd0, if_arready}, 64'd1);
      @(posedge clk); #1;
      if_arvalid = 1'b0;
      addr_phase(0);
      for (int b = 0; b < 8; b++) beat(GRANT_IF, 13'd0, 64'hB100 + 64'(b), b == 7, 1'b0);

`ifdef ARB_ROUND_ROBIN_EN
      // 3: both requesting continuously alternate dm, if, dm, if
      if_arvalid = 1'b1; if_araddr = 64'h3000; if_arlen = 8'd0; if_arsize = SIZE_8B; if_arburst = BURST_INCR;
      dm_arvalid = 1'b1; dm_araddr = 64'h4000; dm_arlen = 8'd0; dm_arsize = SIZE_8B; dm_arburst = BURST_INCR;
      for (int k = 0; k < 4; k++) begin
         logic w;
         w = (k % 2 == 0);
         exp_ar.push_back('{id: {12'd0, w}, addr: w ? 64'h4000 : 64'h3000, len: 8'd0,
                            size: SIZE_8B, burst: BURST_INCR});
         @(negedge clk);
         chk("t3_rr_dm_arready", {63'd0, dm_arready}, {63'd0, w});
         chk("t3_rr_if_arready", {63'd0, if_arready}, {63'd0, !w});
         @(posedge clk); #1;
         if (k == 3) begin
            if_arvalid = 1'b0;
            dm_arvalid = 1'b0;
         end
         addr_phase(0);
         beat(w, {12'd0, w}, 64'hC0 + 64'(k), 1'b1, 1'b0);
      end
`endif

      // 4: if_rready toggles every cycle; rready must mirror, 8 beats exactly
      req_one(GRANT_IF, 64'h5000, 8'd7, SIZE_8B, BURST_INCR);
      addr_phase(0);
      beats_before = beats_seen;
      for (int b = 0; b < 8; b++) beat(GRANT_IF, 13'd0, 64'hD000 + 64'(b), b == 7, 1'b1);
      if_rready = 1'b1;
      @(negedge clk);
      chk("t4_beats_delivered", 64'(beats_seen - beats_before), 64'd8);
      chk("t4_r_drained", 64'(exp_r.size()), 64'd0);
      @(posedge clk); #1;

      // 5a: foreign RID mid-burst is swallowed, burst completes cleanly
      req_one(GRANT_IF, 64'h6000, 8'd7, SIZE_8B, BURST_INCR);
      addr_phase(0);
      for (int b = 0; b < 3; b++) beat(GRANT_IF, 13'd0, 64'hE000 + 64'(b), 1'b0, 1'b0);
      beat(GRANT_IF, 13'd1, 64'hEEEE, 1'b0, 1'b0);
      @(negedge clk);
      chk("t5_err_rid_set", {63'd0, err_rid}, 64'd1);
      chk("t5_err_len_clear", {63'd0, err_len}, 64'd0);
      @(posedge clk); #1;
      for (int b = 3; b < 8; b++) beat(GRANT_IF, 13'd0, 64'hE000 + 64'(b), b == 7, 1'b0);
      @(negedge clk);
      chk("t5_len_ok_after_bad_rid", {63'd0, err_len}, 64'd0);
      @(posedge clk); #1;

      // 5b: early rlast on the 4th beat of a len-7 burst
      req_one(GRANT_IF, 64'h7000, 8'd7, SIZE_8B, BURST_INCR);
      addr_phase(0);
      for (int b = 0; b < 4; b++) beat(GRANT_IF, 13'd0, 64'hF000 + 64'(b), b == 3, 1'b0);
      @(negedge clk);
      chk("t5_err_len_set", {63'd0, err_len}, 64'd1);
      chk("t5_err_rid_sticky", {63'd0, err_rid}, 64'd1);
      chk("t5_back_to_idle", {63'd0, m_axi_rready}, 64'd0);
      @(posedge clk); #1;

      // 6: async reset while beat 3 is on the bus
      req_one(GRANT_IF, 64'h8000, 8'd7, SIZE_8B, BURST_INCR);
      addr_phase(0);
      for (int b = 0; b < 3; b++) beat(GRANT_IF, 13'd0, 64'h8800 + 64'(b), 1'b0, 1'b0);
      m_axi_rvalid = 1'b1; m_axi_rid = 13'd0; m_axi_rdata = 64'h8803; m_axi_rlast = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      chk_all_zero("mid_burst_reset");
      m_axi_rvalid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      req_one(GRANT_DM, 64'h9000, 8'd1, SIZE_8B, BURST_INCR);
      addr_phase(0);
      beat(GRANT_DM, 13'd1, 64'h9900, 1'b0, 1'b0);
      beat(GRANT_DM, 13'd1, 64'h9901, 1'b1, 1'b0);
      @(negedge clk);
      chk("t6_err_rid", {63'd0, err_rid}, 64'd0);
      chk("t6_err_len", {63'd0, err_len}, 64'd0);
      chk("t6_ar_drained", 64'(exp_ar.size()), 64'd0);
      chk("t6_r_drained", 64'(exp_r.size()), 64'd0);
      @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
